// File: rtl/mem_rd_arbiter.sv
// Two-requester (0 = instruction fetch, 1 = data cache) AXI read arbiter, one burst in flight.
// Define DCACHE_PRIORITY_EN to make the data cache win ties instead of round-robin.
module mem_rd_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    output logic [1:0]             req_ready,
    output logic [1:0]             resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_last,
    input  logic                   flush_valid,
    output logic                   ar_valid,
    input  logic                   ar_ready,
    output logic [ADDR_W-1:0]      ar_addr,
    output logic                   ar_id,
    output logic [7:0]             ar_len,
    input  logic                   r_valid,
    output logic                   r_ready,
    input  logic [DATA_W-1:0]      r_data,
    input  logic                   r_last,
    output logic                   protocol_err
);

    localparam logic [3:0] LAST_BEAT  = 4'(BURST_LEN - 1);
    localparam logic [7:0] AR_LEN_VAL = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              id_q, id_d;
    logic [3:0]        beat_q, beat_d;
    logic              drop_q, drop_d;
    logic              ovr_q, ovr_d;
    logic [1:0]        req_ready_q, req_ready_d;
    logic              perr_q, perr_d;
`ifndef DCACHE_PRIORITY_EN
    logic              ptr_q, ptr_d;
`endif
    logic [1:0]        elig_s;
    logic [1:0]        grant_s;
    logic              drop_now_s;
    logic              at_last_s;
    logic              beat_vis_s;
    logic              beat_end_s;

    // Next-state, arbitration and beat bookkeeping
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        id_d        = id_q;
        beat_d      = beat_q;
        drop_d      = drop_q;
        ovr_d       = ovr_q;
        req_ready_d = 2'b00;
        perr_d      = 1'b0;
`ifndef DCACHE_PRIORITY_EN
        ptr_d       = ptr_q;
`endif
        elig_s      = req_valid & {1'b1, ~flush_valid};
        grant_s     = 2'b00;
        drop_now_s  = drop_q;
        at_last_s   = (beat_q == LAST_BEAT);
        beat_vis_s  = 1'b0;
        beat_end_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                ovr_d  = 1'b0;
                beat_d = 4'd0;
                if (elig_s == 2'b11) begin
`ifdef DCACHE_PRIORITY_EN
                    grant_s = 2'b10;
`else
                    grant_s = ptr_q ? 2'b10 : 2'b01;
`endif
                end else begin
                    grant_s = elig_s;
                end
                if (grant_s != 2'b00) begin
                    id_d        = grant_s[1];
                    addr_d      = req_addr[grant_s[1]];
                    req_ready_d = grant_s;
                    state_d     = ST_ADDR;
`ifndef DCACHE_PRIORITY_EN
                    ptr_d       = ~grant_s[1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                drop_now_s = drop_q | (flush_valid & ~id_q);
                drop_d     = drop_now_s;
                if (ar_ready) begin
                    state_d = ST_DATA;
                    beat_d  = 4'd0;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                // A flush in the same cycle as a beat already hides that beat
                drop_now_s = drop_q | (flush_valid & ~id_q);
                drop_d     = drop_now_s;
                if (r_valid) begin
                    beat_vis_s = ~drop_now_s & ~ovr_q;
                    beat_end_s = r_last | at_last_s;
                    perr_d     = (r_last & ~at_last_s) | (~r_last & at_last_s & ~ovr_q);
                    ovr_d      = ovr_q | (at_last_s & ~r_last);
                    beat_d     = at_last_s ? beat_q : beat_q + 4'd1;
                    state_d    = r_last ? ST_IDLE : ST_DATA;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            id_q        <= 1'b0;
            beat_q      <= 4'd0;
            drop_q      <= 1'b0;
            ovr_q       <= 1'b0;
            req_ready_q <= 2'b00;
            perr_q      <= 1'b0;
`ifndef DCACHE_PRIORITY_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            beat_q      <= beat_d;
            drop_q      <= drop_d;
            ovr_q       <= ovr_d;
            req_ready_q <= req_ready_d;
            perr_q      <= perr_d;
`ifndef DCACHE_PRIORITY_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    // Outputs are forced low while rst is high, even before the reset edge lands
    assign ar_valid     = ~rst & (state_q == ST_ADDR);
    assign ar_addr      = ar_valid ? addr_q : {ADDR_W{1'b0}};
    assign ar_id        = ar_valid & id_q;
    assign ar_len       = ar_valid ? AR_LEN_VAL : 8'd0;
    assign r_ready      = ~rst & (state_q == ST_DATA);
    assign resp_valid   = (~rst & beat_vis_s) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_last    = ~rst & beat_vis_s & beat_end_s;
    assign resp_data    = r_ready ? r_data : {DATA_W{1'b0}};
    assign req_ready    = rst ? 2'b00 : req_ready_q;
    assign protocol_err = ~rst & perr_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed self-checking bench for mem_rd_arbiter (default BURST_LEN=4).
module tb_mem_rd_arbiter;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_addr;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_data;
    logic             resp_last;
    logic             flush_valid;
    logic             ar_valid;
    logic             ar_ready;
    logic [31:0]      ar_addr;
    logic             ar_id;
    logic [7:0]       ar_len;
    logic             r_valid;
    logic             r_ready;
    logic [31:0]      r_data;
    logic             r_last;
    logic             protocol_err;
    logic [48:0]      all_out;
    logic [41:0]      ar_vec;

    int n_checks;
    int n_fail;

    mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .flush_valid(flush_valid),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .protocol_err(protocol_err)
    );

    assign all_out = {ar_valid, r_ready, req_ready, resp_valid, resp_last, protocol_err, ar_id, ar_len, ar_addr};
    assign ar_vec  = {ar_valid, ar_id, ar_len, ar_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_beats(input int n);
        for (int b = 0; b < n; b++) begin
            r_valid = 1'b1;
            r_data  = 32'hB000_0000 + 32'(b);
            r_last  = (b == n - 1);
            @(negedge clk);
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
    endtask

    task automatic run_burst;
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        run_beats(4);
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 2'b11; r_valid = 1'b1; flush_valid = 1'b0; ar_ready = 1'b0;
        req_addr[0] = 32'h0; req_addr[1] = 32'h0; r_data = 32'h0; r_last = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (all_out !== 49'd0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", all_out); end
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00; r_valid = 1'b0;
        #1;
        n_checks++;
        if (all_out !== 49'd0) begin n_fail++; $display("FAIL reset_after: got %h want 0", all_out); end
    endtask

    task automatic test_single_fetch;
        @(negedge clk);
        req_valid = 2'b01; req_addr[0] = 32'h100;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL fetch_ready: got %b want 01", req_ready); end
        n_checks++;
        if (ar_vec !== {1'b1, 1'b0, 8'd3, 32'h100}) begin n_fail++; $display("FAIL fetch_ar: got %h want %h", ar_vec, {1'b1, 1'b0, 8'd3, 32'h100}); end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        #1;
        n_checks++;
        if ({ar_valid, r_ready, resp_valid} !== 4'b0100) begin n_fail++; $display("FAIL fetch_data_entry: got %b want 0100", {ar_valid, r_ready, resp_valid}); end
        for (int b = 0; b < 4; b++) begin
            r_valid = 1'b1; r_data = 32'hA000_0000 + 32'(b); r_last = (b == 3);
            #1;
            n_checks++;
            if ({resp_valid, resp_last, resp_data} !== {2'b01, (b == 3), 32'hA000_0000 + 32'(b)}) begin
                n_fail++; $display("FAIL fetch_beat%0d: got %b/%b/%h", b, resp_valid, resp_last, resp_data);
            end
            @(negedge clk);
        end
        r_valid = 1'b0; r_last = 1'b0;
        #1;
        n_checks++;
        if ({r_ready, protocol_err, ar_valid} !== 3'b000) begin n_fail++; $display("FAIL fetch_idle: got %b want 000", {r_ready, protocol_err, ar_valid}); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_second;
`ifdef DCACHE_PRIORITY_EN
        exp_second = 2'b10;
`else
        exp_second = 2'b01;
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b11; req_addr[0] = 32'h200; req_addr[1] = 32'h300;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_checks++;
        if ({req_ready, ar_id, ar_addr} !== {2'b10, 1'b1, 32'h300}) begin n_fail++; $display("FAIL rr_first: got %b/%b/%h want 10/1/300", req_ready, ar_id, ar_addr); end
        run_burst();
        req_valid = 2'b11;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_checks++;
        if (req_ready !== exp_second) begin n_fail++; $display("FAIL rr_second: got %b want %b", req_ready, exp_second); end
        n_checks++;
        if (ar_id !== exp_second[1]) begin n_fail++; $display("FAIL rr_second_id: got %b want %b", ar_id, exp_second[1]); end
        run_burst();
    endtask

    task automatic test_ar_stall;
        @(negedge clk);
        req_valid = 2'b10; req_addr[1] = 32'h440;
        @(negedge clk);
        req_valid = 2'b00;
        for (int i = 0; i < 6; i++) begin
            r_valid = (i < 5);
            r_last  = 1'b0;
            ar_ready = (i == 5);
            #1;
            n_checks++;
            if ({ar_vec, resp_valid, r_ready} !== {1'b1, 1'b1, 8'd3, 32'h440, 2'b00, 1'b0}) begin
                n_fail++; $display("FAIL stall_cyc%0d: got %h/%b/%b", i, ar_vec, resp_valid, r_ready);
            end
            @(negedge clk);
        end
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 32'h55; r_last = 1'b0; flush_valid = 1'b1;
        #1;
        n_checks++;
        if ({resp_valid, resp_data} !== {2'b10, 32'h55}) begin n_fail++; $display("FAIL stall_dcache_flush: got %b/%h want 10/55", resp_valid, resp_data); end
        @(negedge clk);
        flush_valid = 1'b0;
        run_beats(3);
    endtask

    task automatic test_flush;
        @(negedge clk);
        req_valid = 2'b01; req_addr[0] = 32'h500; flush_valid = 1'b1;
        @(negedge clk);
        flush_valid = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, ar_valid} !== 3'b000) begin n_fail++; $display("FAIL flush_idle_block: got %b want 000", {req_ready, ar_valid}); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_checks++;
        if ({req_ready, ar_vec} !== {2'b01, 1'b1, 1'b0, 8'd3, 32'h500}) begin n_fail++; $display("FAIL flush_grant: got %b/%h", req_ready, ar_vec); end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            r_valid = 1'b1; r_data = 32'hC0 + 32'(b); r_last = 1'b0;
            #1;
            n_checks++;
            if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL flush_pre%0d: got %b want 01", b, resp_valid); end
            @(negedge clk);
        end
        r_valid = 1'b0; flush_valid = 1'b1;
        @(negedge clk);
        flush_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            r_valid = 1'b1; r_data = 32'hD0 + 32'(b); r_last = (b == 1);
            #1;
            n_checks++;
            if ({r_ready, resp_valid, resp_last} !== 4'b1000) begin n_fail++; $display("FAIL flush_drop%0d: got %b want 1000", b, {r_ready, resp_valid, resp_last}); end
            @(negedge clk);
        end
        r_valid = 1'b0; r_last = 1'b0;
        req_valid = 2'b01; req_addr[0] = 32'h600;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_checks++;
        if ({req_ready, ar_addr} !== {2'b01, 32'h600}) begin n_fail++; $display("FAIL flush_next_grant: got %b/%h want 01/600", req_ready, ar_addr); end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 32'hE0; r_last = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL flush_cleared: got %b want 01", resp_valid); end
        @(negedge clk);
        run_beats(3);
    endtask

    task automatic test_early_last;
        @(negedge clk);
        req_valid = 2'b10; req_addr[1] = 32'h700;
        @(negedge clk);
        req_valid = 2'b00; ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        r_valid = 1'b1; r_last = 1'b0;
        #1;
        n_checks++;
        if ({resp_valid, resp_last} !== 3'b100) begin n_fail++; $display("FAIL early_beat1: got %b want 100", {resp_valid, resp_last}); end
        @(negedge clk);
        r_last = 1'b1;
        #1;
        n_checks++;
        if ({resp_valid, resp_last, protocol_err} !== 4'b1010) begin n_fail++; $display("FAIL early_beat2: got %b want 1010", {resp_valid, resp_last, protocol_err}); end
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0;
        #1;
        n_checks++;
        if ({protocol_err, r_ready} !== 2'b10) begin n_fail++; $display("FAIL early_err: got %b want 10", {protocol_err, r_ready}); end
        @(negedge clk);
        #1;
        n_checks++;
        if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL early_err_pulse: got %b want 0", protocol_err); end
    endtask

    task automatic test_overrun;
        @(negedge clk);
        req_valid = 2'b10; req_addr[1] = 32'h780;
        @(negedge clk);
        req_valid = 2'b00; ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            r_valid = 1'b1; r_last = 1'b0;
            #1;
            n_checks++;
            if ({resp_valid, resp_last} !== {2'b10, (b == 3)}) begin n_fail++; $display("FAIL ovr_beat%0d: got %b", b, {resp_valid, resp_last}); end
            @(negedge clk);
        end
        r_valid = 1'b0;
        #1;
        n_checks++;
        if ({protocol_err, r_ready} !== 2'b11) begin n_fail++; $display("FAIL ovr_err: got %b want 11", {protocol_err, r_ready}); end
        @(negedge clk);
        r_valid = 1'b1; r_last = 1'b1;
        #1;
        n_checks++;
        if ({resp_valid, resp_last, r_ready} !== 4'b0001) begin n_fail++; $display("FAIL ovr_tail: got %b want 0001", {resp_valid, resp_last, r_ready}); end
        @(negedge clk);
        r_valid = 1'b0; r_last = 1'b0;
        #1;
        n_checks++;
        if ({r_ready, protocol_err} !== 2'b00) begin n_fail++; $display("FAIL ovr_idle: got %b want 00", {r_ready, protocol_err}); end
    endtask

    task automatic test_reset_mid_data;
        @(negedge clk);
        req_valid = 2'b01; req_addr[0] = 32'h800;
        @(negedge clk);
        req_valid = 2'b00; ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0; r_valid = 1'b1; r_last = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL rstmid_beat: got %b want 01", resp_valid); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 49'd0) begin n_fail++; $display("FAIL rstmid_hold: got %h want 0", all_out); end
        @(negedge clk);
        rst = 1'b0; r_valid = 1'b0;
        #1;
        n_checks++;
        if (all_out !== 49'd0) begin n_fail++; $display("FAIL rstmid_after: got %h want 0", all_out); end
        req_valid = 2'b01; req_addr[0] = 32'h900;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_checks++;
        if ({req_ready, ar_vec} !== {2'b01, 1'b1, 1'b0, 8'd3, 32'h900}) begin n_fail++; $display("FAIL rstmid_grant: got %b/%h", req_ready, ar_vec); end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            r_valid = 1'b1; r_data = 32'hF0 + 32'(b); r_last = (b == 3);
            #1;
            n_checks++;
            if ({resp_valid, resp_last} !== {2'b01, (b == 3)}) begin n_fail++; $display("FAIL rstmid_beat%0d: got %b", b, {resp_valid, resp_last}); end
            @(negedge clk);
        end
        r_valid = 1'b0; r_last = 1'b0;
        #1;
        n_checks++;
        if ({r_ready, protocol_err} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle: got %b want 00", {r_ready, protocol_err}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_ar_stall();
        test_flush();
        test_early_last();
        test_overrun();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, read data width.
REQ-003 SHALL have parameter BURST_LEN, default 4, beats per burst (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req_valid[i] input 1, req_addr[i] input ADDR_W, req_ready[i] output 1; i=0 instruction fetch, i=1 data cache.
REQ-007 SHALL have ports resp_valid[i] output 1, resp_data output DATA_W (shared), resp_last output 1 (shared).
REQ-008 SHALL have port flush_valid  input  1  pipeline flush; cancels the pending or in-flight fetch (requester 0) response.
REQ-009 SHALL have AXI read-master ports ar_valid out 1, ar_ready in 1, ar_addr out ADDR_W, ar_id out 1, ar_len out 8, r_valid in 1, r_ready out 1, r_data in DATA_W, r_last in 1.
REQ-010 SHALL have port protocol_err  output  1  one-cycle pulse on burst-length mismatch.

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-012 IDLE: on any req_valid, SHALL grant one requester, pulse its req_ready for 1 cycle, latch addr and id, go to ADDR; a request sampled in cycle N gives ar_valid in cycle N+1.
REQ-013 Without DCACHE_PRIORITY_EN, SHALL arbitrate round-robin: on simultaneous requests, grant the requester not granted last; after reset, requester 1 (data) wins first.
REQ-014 ADDR: SHALL hold ar_valid=1 with stable ar_addr, ar_id=granted index, ar_len=BURST_LEN-1 until ar_ready; on the handshake, go to DATA with the beat counter at 0.
REQ-015 DATA: SHALL drive r_ready=1; on each r_valid, SHALL forward r_data combinationally to resp_data and assert resp_valid[ar_id], increment the beat counter, and assert resp_last on the final beat.
REQ-016 On r_valid&r_last with counter==BURST_LEN-1, SHALL return to IDLE in the next cycle; no new grant happens in the same cycle as the last beat.
REQ-017 On r_last early (counter<BURST_LEN-1), or counter reaching BURST_LEN-1 without r_last, SHALL pulse protocol_err, end the response with resp_last, and go to IDLE when r_last arrives.
REQ-018 flush_valid while the granted id=0 in ADDR or DATA SHALL set a drop flag; the AXI transaction SHALL still complete (ar handshake, all beats consumed with r_ready=1), but resp_valid[0] SHALL stay 0 for the remaining beats; the flag clears on return to IDLE.
REQ-019 flush_valid in IDLE SHALL suppress a grant to requester 0 in that cycle only.
REQ-020 flush_valid SHALL NOT affect a data-cache (id=1) transaction.
REQ-021 r_valid outside DATA SHALL be ignored with r_ready=0.
REQ-022 The module SHALL have at most one outstanding AXI transaction.

Reset
REQ-023 rst=1 SHALL force IDLE, clear the beat counter, drop flag and round-robin pointer (pointing to requester 1), regardless of state; a mid-burst reset abandons the transaction.
REQ-024 While rst=1 and in the cycle after, all outputs SHALL be 0: ar_valid, r_ready, req_ready, resp_valid, resp_last, protocol_err, ar_addr, ar_len, ar_id.

Configuration
REQ-025 Macro DCACHE_PRIORITY_EN defined: requester 1 SHALL always win simultaneous requests, and no round-robin pointer is built.
REQ-026 Macro DCACHE_PRIORITY_EN undefined: arbitration SHALL be round-robin per REQ-013.

Verification
REQ-027 Single fetch: req_valid[0], addr 0x100, ar_ready=1 immediately, 4 beats -> ar_valid next cycle, ar_addr=0x100, ar_len=3, ar_id=0, resp_valid[0] x4, resp_last on beat 4, IDLE after.
REQ-028 Simultaneous req[0] and req[1] right after reset, twice -> grants in order 1,0 (round-robin); with DCACHE_PRIORITY_EN -> 1,1.
REQ-029 ar_ready held low 5 cycles -> ar_valid and ar_addr stable for all 6 cycles; no resp before the handshake.
REQ-030 flush_valid after beat 2 of a fetch -> beats 3-4 accepted (r_ready=1), resp_valid[0]=0, next grant starts normally.
REQ-031 r_last on beat 2 with BURST_LEN=4 -> protocol_err pulse, resp_last on beat 2, IDLE next cycle.
REQ-032 rst asserted mid-DATA -> all outputs 0 next cycle; a fresh request afterwards completes cleanly.
